// File: rtl/mips_selftest.sv
// Self-test sequencer: resets and runs a MIPS core, then scans data memory against a table of expected words.
// Latency: RESET_CYCLES + RUN_CYCLES + (2 per enabled entry, 1 per disabled entry) cycles from start to done.
module mips_selftest #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 8,
    parameter int NUM_CHECKS   = 4,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 200,
    localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int FC_W  = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              core_reset,
    output logic              dbg_rd_en,
    output logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [FC_W-1:0]   fail_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_data
);

    localparam int MAX_CYC = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {IDLE, RST_CORE, RUN, READ, CMP, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [NUM_CHECKS-1:0] en_q;
    logic [ADDR_W-1:0]   addr_tab_q [NUM_CHECKS];
    logic [DATA_W-1:0]   data_tab_q [NUM_CHECKS];

    logic                core_reset_q;
    logic                dbg_rd_en_q;
    logic [ADDR_W-1:0]   dbg_addr_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [FC_W-1:0]     fail_count_q;
    logic [IDX_W-1:0]    first_fail_idx_q;
    logic [DATA_W-1:0]   first_fail_data_q;

    logic                tab_wr;
    logic                last_entry;
    logic [IDX_W-1:0]    ptr_d;
    logic                nxt_en;
    logic [ADDR_W-1:0]   nxt_addr;
    logic                mismatch;
    logic [FC_W-1:0]     fail_count_d;

    // Table is only writable while no test is in flight.
    assign tab_wr = exp_we && (state_q == IDLE || state_q == DONE)
                    && (int'(exp_idx) < NUM_CHECKS);

    assign last_entry   = (int'(ptr_q) == NUM_CHECKS - 1);
    assign ptr_d        = ptr_q + 1'b1;
    assign nxt_en       = en_q[ptr_d];
    assign nxt_addr     = nxt_en ? addr_tab_q[ptr_d] : '0;
    assign mismatch     = (dbg_rd_data != data_tab_q[ptr_q]);
    assign fail_count_d = mismatch ? fail_count_q + 1'b1 : fail_count_q;

    always_ff @(posedge clk) begin
        if (tab_wr) begin
            addr_tab_q[exp_idx] <= exp_addr;
            data_tab_q[exp_idx] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            ptr_q             <= '0;
            en_q              <= '0;
            core_reset_q      <= 1'b1;
            dbg_rd_en_q       <= 1'b0;
            dbg_addr_q        <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            fail_count_q      <= '0;
            first_fail_idx_q  <= '0;
            first_fail_data_q <= '0;
        end else begin
            if (tab_wr) begin
                en_q[exp_idx] <= 1'b1;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q           <= RST_CORE;
                        cnt_q             <= CNT_W'(RESET_CYCLES - 1);
                        core_reset_q      <= 1'b1;
                        busy_q            <= 1'b1;
                        done_q            <= 1'b0;
                        pass_q            <= 1'b0;
                        fail_count_q      <= '0;
                        first_fail_idx_q  <= '0;
                        first_fail_data_q <= '0;
                    end
                end
                RST_CORE: begin
                    if (cnt_q == '0) begin
                        state_q      <= RUN;
                        cnt_q        <= CNT_W'(RUN_CYCLES - 1);
                        core_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        // Read strobe is registered, so it is set up on entry to READ.
                        state_q     <= READ;
                        ptr_q       <= '0;
                        dbg_rd_en_q <= en_q[0];
                        dbg_addr_q  <= en_q[0] ? addr_tab_q[0] : '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                READ: begin
                    dbg_rd_en_q <= 1'b0;
                    dbg_addr_q  <= '0;
                    if (en_q[ptr_q]) begin
                        state_q <= CMP;
                    end else if (last_entry) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_count_q == '0);
                    end else begin
                        ptr_q       <= ptr_d;
                        dbg_rd_en_q <= nxt_en;
                        dbg_addr_q  <= nxt_addr;
                    end
                end
                CMP: begin
                    fail_count_q <= fail_count_d;
                    if (mismatch && fail_count_q == '0) begin
                        first_fail_idx_q  <= ptr_q;
                        first_fail_data_q <= dbg_rd_data;
                    end
                    if (last_entry) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_count_d == '0);
                    end else begin
                        state_q     <= READ;
                        ptr_q       <= ptr_d;
                        dbg_rd_en_q <= nxt_en;
                        dbg_addr_q  <= nxt_addr;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core_reset      = core_reset_q;
    assign dbg_rd_en       = dbg_rd_en_q;
    assign dbg_addr        = dbg_addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign fail_count      = fail_count_q;
    assign first_fail_idx  = first_fail_idx_q;
    assign first_fail_data = first_fail_data_q;

endmodule

// File: tb/tb_mips_selftest.sv
// Bench for mips_selftest: table of table-load/expected-result vectors, a data-memory model and a read-address scoreboard.
module tb_mips_selftest;

    localparam int RST_C = 2;
    localparam int RUN_C = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        exp_we;
    logic [1:0]  exp_idx;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic        core_reset;
    logic        dbg_rd_en;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_rd_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  fail_count;
    logic [1:0]  first_fail_idx;
    logic [31:0] first_fail_data;

    mips_selftest dut (
        .clk(clk), .reset(reset), .start(start),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .core_reset(core_reset), .dbg_rd_en(dbg_rd_en), .dbg_addr(dbg_addr),
        .dbg_rd_data(dbg_rd_data), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx),
        .first_fail_data(first_fail_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) dbg_rd_data <= mem[dbg_addr];

    int tests = 0;
    int fails = 0;
    int addr_viol = 0;
    logic [7:0] exp_q [$];
    logic [3:0] cur_mask;
    logic [3:0][7:0] cur_addr;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Scoreboard: every read strobe must match the next expected address.
    always @(negedge clk) begin
        if (!reset && dbg_rd_en) begin
            if (exp_q.size() == 0) check("unexpected_read", {56'd0, dbg_addr}, 64'hFFFF);
            else check("rd_addr", {56'd0, dbg_addr}, {56'd0, exp_q.pop_front()});
        end
        if (!dbg_rd_en && dbg_addr != 8'd0) addr_viol++;
    end

    typedef struct packed {
        logic [3:0]        mask;
        logic [3:0][7:0]   addr;
        logic [3:0][31:0]  data;
        logic [3:0][31:0]  memv;
        logic              e_pass;
        int                e_fc;
        int                e_ffi;
        logic [31:0]       e_ffd;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    function automatic int exp_cyc(input logic [3:0] m);
        int c = RST_C + RUN_C;
        for (int i = 0; i < 4; i++) c += m[i] ? 2 : 1;
        return c;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic setup(input vec_t v);
        do_reset();
        cur_mask = v.mask;
        cur_addr = v.addr;
        for (int i = 0; i < 4; i++) begin
            if (v.mask[i]) begin
                mem[v.addr[i]] = v.memv[i];
                exp_we = 1'b1; exp_idx = 2'(i); exp_addr = v.addr[i]; exp_data = v.data[i];
                @(posedge clk); #1;
            end
        end
        exp_we = 1'b0;
    endtask

    // mode 0: clean run; 1: start during RUN and table write during READ; 2: table write with start
    task automatic run_test(input string tag, input logic e_pass, input int e_fc, input int e_ffi,
                            input logic [31:0] e_ffd, input int mode);
        int k = 0;
        int viol = 0;
        int done_k = -1;
        int want = exp_cyc(cur_mask);
        addr_viol = 0;
        for (int i = 0; i < 4; i++) if (cur_mask[i]) exp_q.push_back(cur_addr[i]);
        start = 1'b1;
        if (mode == 2) begin
            exp_we = 1'b1; exp_idx = 2'd0; exp_addr = 8'h40; exp_data = 32'h77;
        end
        @(posedge clk); #1;
        start = 1'b0; exp_we = 1'b0;
        while (k < 3000) begin
            @(negedge clk);
            if (k == 0) begin
                check({tag, "_clear"}, {58'd0, done, pass, fail_count, first_fail_idx}, 64'd0);
                check({tag, "_clear_ffd"}, {32'd0, first_fail_data}, 64'd0);
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (core_reset !== (k < RST_C)) viol++;
            if (busy !== 1'b1) viol++;
            @(posedge clk); #1;
            k++;
            start    = (mode == 1 && k == 50);
            exp_we   = (mode == 1 && k == RST_C + RUN_C);
            exp_idx  = 2'd2; exp_addr = 8'h77; exp_data = 32'h12345678;
        end
        start = 1'b0; exp_we = 1'b0;
        check({tag, "_done_cycle"}, 64'(done_k), 64'(want));
        check({tag, "_cr_busy_seq"}, 64'(viol), 64'd0);
        check({tag, "_pass"}, {63'd0, pass}, {63'd0, e_pass});
        check({tag, "_fail_count"}, {61'd0, fail_count}, 64'(e_fc));
        if (e_fc != 0) begin
            check({tag, "_ffi"}, {62'd0, first_fail_idx}, 64'(e_ffi));
            check({tag, "_ffd"}, {32'd0, first_fail_data}, {32'd0, e_ffd});
        end
        check({tag, "_reads_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_addr_idle"}, 64'(addr_viol), 64'd0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_held"}, {61'd0, done, busy, core_reset}, 64'b100);
    endtask

    initial begin
        logic [3:0][7:0] a;
        reset = 1'b1; start = 1'b0; exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A50000 | 32'(i);

        vecs[0] = '{4'b0001, {8'h0, 8'h0, 8'h0, 8'h00},
                    {32'h0, 32'h0, 32'h0, 32'h6}, {32'h0, 32'h0, 32'h0, 32'h6},
                    1'b1, 0, 0, 32'h0};
        vecs[1] = '{4'b1111, {8'h13, 8'h12, 8'h11, 8'h10},
                    {32'hD, 32'hC, 32'hB, 32'hA}, {32'hD, 32'hDEADBEEF, 32'hB, 32'hA},
                    1'b0, 1, 2, 32'hDEADBEEF};
        vecs[2] = '{4'b0000, {8'h0, 8'h0, 8'h0, 8'h0},
                    {32'h0, 32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h0, 32'h0},
                    1'b1, 0, 0, 32'h0};
        vecs[3] = '{4'b0101, {8'h0, 8'h22, 8'h0, 8'h20},
                    {32'h0, 32'h33, 32'h0, 32'h11111111}, {32'h0, 32'h34, 32'h0, 32'h11111112},
                    1'b0, 2, 0, 32'h11111112};
        vecs[4] = '{4'b1000, {8'hFF, 8'h0, 8'h0, 8'h0},
                    {32'hCAFEF00D, 32'h0, 32'h0, 32'h0}, {32'hCAFEF00D, 32'h0, 32'h0, 32'h0},
                    1'b1, 0, 0, 32'h0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_core_reset", {63'd0, core_reset}, 64'd1);
        check("rst_busy_done_pass", {61'd0, busy, done, pass}, 64'd0);
        check("rst_fail_count", {61'd0, fail_count}, 64'd0);
        check("rst_dbg", {55'd0, dbg_rd_en, dbg_addr}, 64'd0);
        check("rst_first_fail", {30'd0, first_fail_idx, first_fail_data}, 64'd0);

        for (int v = 0; v < NV; v++) begin
            setup(vecs[v]);
            run_test($sformatf("vec%0d", v), vecs[v].e_pass, vecs[v].e_fc, vecs[v].e_ffi,
                     vecs[v].e_ffd, 0);
        end

        // Ignored start/table write mid-test, then a back-to-back rerun on the persisting table.
        setup(vecs[1]);
        run_test("interfere", 1'b0, 1, 2, 32'hDEADBEEF, 1);
        run_test("rerun", 1'b0, 1, 2, 32'hDEADBEEF, 0);

        // Table write in the same cycle as start is used by that run.
        do_reset();
        mem[8'h40] = 32'h77;
        cur_mask = 4'b0001;
        a = '0; a[0] = 8'h40;
        cur_addr = a;
        run_test("wr_with_start", 1'b1, 0, 0, 32'h0, 2);

        // Reset while in CMP.
        setup(vecs[1]);
        for (int i = 0; i < 4; i++) exp_q.push_back(cur_addr[i]);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        begin
            int w = 0;
            while (w < 400) begin
                @(negedge clk);
                if (dbg_rd_en) break;
                w++;
            end
            check("cmp_wait_read", 64'(w < 400), 64'd1);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("cmpreset_core_reset", {63'd0, core_reset}, 64'd1);
        check("cmpreset_status", {60'd0, busy, done, pass, dbg_rd_en}, 64'd0);
        check("cmpreset_fail_count", {61'd0, fail_count}, 64'd0);
        exp_q.delete();
        cur_mask = 4'b0000;
        run_test("after_reset", 1'b1, 0, 0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_selftest.md
MIPS_SELFTEST -- requirements
Module: mips_selftest

Interface
REQ-001 The block SHALL have parameters (name, default, meaning):
- DATA_W, 32, data word width
- ADDR_W, 8, debug word-address width
- NUM_CHECKS, 4, expected-value table entries
- RESET_CYCLES, 2, cycles the core is held in reset per run
- RUN_CYCLES, 200, cycles the core runs before the scan

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that launches a self-test
- exp_we  in  1  table write strobe
- exp_idx  in  clog2(NUM_CHECKS)  table entry index
- exp_addr  in  ADDR_W  data-memory word address to check
- exp_data  in  DATA_W  expected word
- core_reset  out  1  reset driven to the MIPS core
- dbg_rd_en  out  1  debug read request to data memory
- dbg_addr  out  ADDR_W  debug read address
- dbg_rd_data  in  DATA_W  debug read data, valid one cycle after dbg_rd_en
- busy  out  1  test in progress
- done  out  1  test finished; held until the next start
- pass  out  1  all enabled checks matched; valid when done=1
- fail_count  out  clog2(NUM_CHECKS+1)  number of mismatches
- first_fail_idx  out  clog2(NUM_CHECKS)  index of the first mismatch
- first_fail_data  out  DATA_W  word read at the first mismatch

Function
REQ-003 The FSM SHALL have states IDLE, RST_CORE, RUN, READ, CMP and DONE.
REQ-004 In IDLE, core_reset SHALL be 1 and busy SHALL be 0.
REQ-005 On start in IDLE or DONE, the FSM SHALL go to RST_CORE and clear done, pass, fail_count, first_fail_idx and first_fail_data.
REQ-006 RST_CORE SHALL last exactly RESET_CYCLES cycles with core_reset=1, then go to RUN.
REQ-007 RUN SHALL last exactly RUN_CYCLES cycles with core_reset=0, then go to READ with entry pointer 0.
REQ-008 core_reset SHALL stay 0 from RUN until the FSM returns to IDLE.
REQ-009 In READ, if the current entry is enabled, the block SHALL drive dbg_rd_en=1 and dbg_addr=table addr for one cycle, then go to CMP.
REQ-010 In READ, a disabled entry SHALL be skipped without a read; the pointer SHALL advance in the same cycle.
REQ-011 In CMP, the block SHALL compare dbg_rd_data with the expected word. On mismatch it SHALL increment fail_count; if fail_count was 0, it SHALL also latch first_fail_idx and first_fail_data.
REQ-012 After the last entry (NUM_CHECKS-1) is processed, the FSM SHALL go to DONE: done=1, busy=0, pass=(fail_count==0).
REQ-013 dbg_rd_en SHALL be 0 in every state except READ with an enabled entry; dbg_addr SHALL be 0 when dbg_rd_en is 0.
REQ-014 busy SHALL be 1 in RST_CORE, RUN, READ and CMP.
REQ-015 An exp_we in IDLE or DONE SHALL write addr/data to entry exp_idx and set that entry's enable bit.
REQ-016 An exp_we while busy=1 SHALL be ignored.
REQ-017 If exp_we and start occur in the same cycle, the table write SHALL take effect first and the run SHALL use the new entry.
REQ-018 A start while busy=1 SHALL be ignored.
REQ-019 If all entries are disabled, the block SHALL issue no reads, and DONE SHALL show pass=1, fail_count=0.
REQ-020 The RST_CORE/RUN cycle counter SHALL be wide enough for max(RESET_CYCLES, RUN_CYCLES) and SHALL reload on each state entry.

Reset
REQ-021 When reset=1, the block SHALL go to IDLE with core_reset=1 and dbg_rd_en=0, and clear busy, done, pass, fail_count, first_fail_idx, first_fail_data, dbg_addr and all table enable bits, including when reset arrives mid-test.
REQ-022 Table addr/data contents SHALL be don't-care after reset.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Load idx0 = (addr 0, data 0x00000006); the model returns 0x6 at addr 0; start -> core_reset=1 for 2 cycles, then 0 for 200 cycles; one read of addr 0; done=1, pass=1, fail_count=0.
- Load idx0-3 with the model matching all except idx2 (returns 0xDEADBEEF) -> fail_count=1, first_fail_idx=2, first_fail_data=0xDEADBEEF, pass=0.
- No entries loaded; start -> zero dbg_rd_en pulses; done=1 at start+2+200+4 cycles (one skip cycle per entry); pass=1.
- Start pulsed during RUN, and exp_we issued during READ -> no effect on timing or the table; the result matches a clean run.
- reset asserted in CMP -> next cycle IDLE, core_reset=1, done=0, enables cleared; a following start with no loads passes.
- Two back-to-back runs from DONE -> the second run clears all status first; the table persists; results are identical.
